// File: rtl/ee357_alu_mdu.sv
// ee357_alu_mdu: execute-stage ALU with WIDTH-generic flags, SLT/SLTU and an
// iterative multiply/divide unit that owns the HI/LO registers. Single-cycle
// ops are purely combinational; MULT/MULTU/DIV/DIVU take WIDTH+1 cycles from
// start to done and hold busy high so the control FSM can stall.
module ee357_alu_mdu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic [5:0]       func,
  input  logic             start,
  output logic [WIDTH-1:0] res,
  output logic             zero,
  output logic             cout,
  output logic             uov,
  output logic             sov,
  output logic             busy,
  output logic             done
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_MFHI = 6'h10;
  localparam logic [5:0] F_MTHI = 6'h11;
  localparam logic [5:0] F_MFLO = 6'h12;
  localparam logic [5:0] F_MTLO = 6'h13;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] hi, lo;

  // ---------------------------------------------------------------------
  // Combinational ALU
  // ---------------------------------------------------------------------
  logic             sub_op;
  logic [WIDTH-1:0] opb_x;
  logic [WIDTH:0]   sum;
  logic             sov_raw;
  logic [SHW-1:0]   shamt;

  assign sub_op  = (func == F_SUB) || (func == F_SLT) || (func == F_SLTU);
  assign opb_x   = sub_op ? ~opb : opb;
  assign sum     = {1'b0, opa} + {1'b0, opb_x} + {{WIDTH{1'b0}}, sub_op};
  assign sov_raw = (opa[WIDTH-1] == opb_x[WIDTH-1]) && (sum[WIDTH-1] != opa[WIDTH-1]);
  assign shamt   = opa[SHW-1:0];

  // Result and flag selection; unknown codes fall back to a flagless add
  always_comb begin
    res  = opa + opb;
    cout = 1'b0;
    uov  = 1'b0;
    sov  = 1'b0;
    case (func)
      F_SLL:  res = opb << shamt;
      F_SRL:  res = opb >> shamt;
      F_SRA:  res = $signed(opb) >>> shamt;
      F_MFHI: res = hi;
      F_MFLO: res = lo;
      F_ADD: begin
        res  = sum[WIDTH-1:0];
        cout = sum[WIDTH];
        uov  = sum[WIDTH];
        sov  = sov_raw;
      end
      F_SUB: begin
        res  = sum[WIDTH-1:0];
        cout = sum[WIDTH];
        uov  = ~sum[WIDTH];
        sov  = sov_raw;
      end
      F_AND:  res = opa & opb;
      F_OR:   res = opa | opb;
      F_XOR:  res = opa ^ opb;
      F_NOR:  res = ~(opa | opb);
      F_SLT: begin
        res  = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ sov_raw};
        cout = sum[WIDTH];
        uov  = ~sum[WIDTH];
        sov  = sov_raw;
      end
      F_SLTU: begin
        res  = {{(WIDTH-1){1'b0}}, ~sum[WIDTH]};
        cout = sum[WIDTH];
        uov  = ~sum[WIDTH];
      end
      default: ;
    endcase
  end

  assign zero = (res == '0);

  // ---------------------------------------------------------------------
  // Multiply / divide unit
  // acc/qr form a 2*WIDTH shift pair: product {acc,qr} for multiply,
  // remainder acc and quotient qr for divide. mr holds the multiplicand or
  // divisor magnitude.
  // ---------------------------------------------------------------------
  logic             md_req;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] acc, qr, mr;
  logic             is_div, neg_res, rem_neg;

  logic [WIDTH:0]     mul_add;
  logic [WIDTH:0]     div_sh, div_trial;
  logic               div_ok;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign md_req = start && (func[5:2] == 4'b0110);
  assign a_neg  = ~func[0] & opa[WIDTH-1];
  assign b_neg  = ~func[0] & opb[WIDTH-1];
  assign a_mag  = a_neg ? -opa : opa;
  assign b_mag  = b_neg ? -opb : opb;

  assign mul_add   = {1'b0, acc} + (qr[0] ? {1'b0, mr} : {(WIDTH+1){1'b0}});
  assign div_sh    = {acc, qr[WIDTH-1]};
  assign div_trial = div_sh - {1'b0, mr};
  assign div_ok    = ~div_trial[WIDTH];

  // A zero divisor leaves every trial subtraction successful, so the quotient
  // is forced to all-ones and the remainder recovers the dividend after its
  // sign is restored.
  assign prod_fix = neg_res ? -{acc, qr} : {acc, qr};
  assign quo_fix  = (mr == '0) ? '1 : (neg_res ? -qr : qr);
  assign rem_fix  = rem_neg ? -acc : acc;

  assign busy = (state != S_IDLE);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // FSM next-state: accept a request in IDLE, iterate WIDTH times, then fix up
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (md_req) state_nx = S_RUN;
      S_RUN:   if (cnt == CNT_LAST) state_nx = S_FIX;
      S_FIX:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Operand latch on entry and one shift-add / restoring step per RUN cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      acc     <= '0;
      qr      <= '0;
      mr      <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      rem_neg <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (md_req) begin
            cnt     <= '0;
            acc     <= '0;
            qr      <= a_mag;
            mr      <= b_mag;
            is_div  <= func[1];
            neg_res <= a_neg ^ b_neg;
            rem_neg <= a_neg;
          end
        end
        S_RUN: begin
          cnt <= cnt + 1'b1;
          if (is_div) begin
            acc <= div_ok ? div_trial[WIDTH-1:0] : div_sh[WIDTH-1:0];
            qr  <= {qr[WIDTH-2:0], div_ok};
          end else begin
            acc <= mul_add[WIDTH:1];
            qr  <= {mul_add[0], qr[WIDTH-1:1]};
          end
        end
        default: ;
      endcase
    end
  end

  // HI/LO: written by the FIX step, otherwise by MTHI/MTLO when not busy
  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (state == S_FIX) begin
      if (is_div) begin
        hi <= rem_fix;
        lo <= quo_fix;
      end else begin
        hi <= prod_fix[2*WIDTH-1:WIDTH];
        lo <= prod_fix[WIDTH-1:0];
      end
    end else if (!busy) begin
      if (func == F_MTHI) hi <= opa;
      if (func == F_MTLO) lo <= opa;
    end
  end

  // done pulses for the single cycle after HI/LO are written
  always_ff @(posedge clk) begin
    if (rst) done <= 1'b0;
    else     done <= (state == S_FIX);
  end

endmodule

// File: tb/tb_ee357_alu_mdu.sv
// tb_ee357_alu_mdu: directed vector bench for ee357_alu_mdu at WIDTH 32 and 8.
module tb_ee357_alu_mdu;

  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03;
  localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13;
  localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B;
  localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25;
  localparam logic [5:0] F_XOR = 6'h26, F_NOR = 6'h27, F_SLT = 6'h2A, F_SLTU = 6'h2B;

  typedef struct {
    logic [5:0]  func;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        cout;
    logic        uov;
    logic        sov;
  } comb_vec_t;

  typedef struct {
    logic [5:0]  func;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } md_vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] opa, opb, res;
  logic [5:0]  func;
  logic        start, zero, cout, uov, sov, busy, done;

  logic [7:0]  opa8, opb8, res8;
  logic [5:0]  func8;
  logic        start8, zero8, cout8, uov8, sov8, busy8, done8;

  int checks = 0;
  int errors = 0;

  comb_vec_t cv[20];
  md_vec_t   mv[9];

  always #5 clk = ~clk;

  ee357_alu_mdu #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .opa(opa), .opb(opb), .func(func), .start(start),
    .res(res), .zero(zero), .cout(cout), .uov(uov), .sov(sov),
    .busy(busy), .done(done)
  );

  ee357_alu_mdu #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .opa(opa8), .opb(opb8), .func(func8), .start(start8),
    .res(res8), .zero(zero8), .cout(cout8), .uov(uov8), .sov(sov8),
    .busy(busy8), .done(done8)
  );

  // Compare one observed value against its expected value
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive a combinational operation and let it settle
  task automatic applyStimulus(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    func = f;
    opa  = a;
    opb  = b;
    #1;
  endtask

  // Read HI and LO through MFHI/MFLO without clocking
  task automatic readHiLo(input string tag, input logic [31:0] ehi, input logic [31:0] elo);
    func = F_MFHI;
    #1;
    checkOutput({tag, " HI"}, res, ehi);
    func = F_MFLO;
    #1;
    checkOutput({tag, " LO"}, res, elo);
  endtask

  // Issue a mul/div, wait for done with a cycle bound, check latency and HI/LO
  task automatic runMulDiv(input string tag, input logic [5:0] f, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    int n;
    opa   = a;
    opb   = b;
    func  = f;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput({tag, " busy/done after E0"}, {busy, done}, 2'b10);
    n = 0;
    while (!done && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput({tag, " latency"}, n, 33);
    checkOutput({tag, " busy in done cycle"}, busy, 1'b0);
    readHiLo(tag, ehi, elo);
  endtask

  // Watchdog so a stuck design still ends the run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "[TB] timeout");
  end

  // Main directed sequence
  initial begin
    int n, dn, first;

    cv[0]  = '{F_SLT,  32'h80000000, 32'h00000001, 32'h00000001, 1'b1, 1'b0, 1'b1};
    cv[1]  = '{F_SLTU, 32'h80000000, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0};
    cv[2]  = '{F_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1'b1};
    cv[3]  = '{F_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 1'b0};
    cv[4]  = '{F_SUB,  32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b0};
    cv[5]  = '{F_SUB,  32'h00000007, 32'h00000005, 32'h00000002, 1'b1, 1'b0, 1'b0};
    cv[6]  = '{F_SLT,  32'h00000005, 32'h00000007, 32'h00000001, 1'b0, 1'b1, 1'b0};
    cv[7]  = '{F_SLTU, 32'h00000007, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b0};
    cv[8]  = '{F_SLTU, 32'h00000005, 32'h00000007, 32'h00000001, 1'b0, 1'b1, 1'b0};
    cv[9]  = '{F_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0};
    cv[10] = '{F_OR,   32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b0, 1'b0};
    cv[11] = '{F_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0, 1'b0};
    cv[12] = '{F_NOR,  32'hF0F0F0F0, 32'h0F0F0F0F, 32'h00000000, 1'b0, 1'b0, 1'b0};
    cv[13] = '{F_SLL,  32'h00000004, 32'h00000001, 32'h00000010, 1'b0, 1'b0, 1'b0};
    cv[14] = '{F_SRL,  32'h00000004, 32'h80000000, 32'h08000000, 1'b0, 1'b0, 1'b0};
    cv[15] = '{F_SRA,  32'h00000004, 32'h80000000, 32'hF8000000, 1'b0, 1'b0, 1'b0};
    cv[16] = '{F_SRA,  32'h00000024, 32'h80000000, 32'hF8000000, 1'b0, 1'b0, 1'b0};
    cv[17] = '{6'h3F,  32'h00000003, 32'h00000004, 32'h00000007, 1'b0, 1'b0, 1'b0};
    cv[18] = '{F_SLT,  32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1'b0, 1'b1, 1'b1};
    cv[19] = '{6'h21,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 1'b0};

    mv[0] = '{F_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
    mv[1] = '{F_MULTU, 32'hFFFFFFFD, 32'h00000005, 32'h00000004, 32'hFFFFFFF1};
    mv[2] = '{F_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    mv[3] = '{F_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
    mv[4] = '{F_DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF};
    mv[5] = '{F_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF};
    mv[6] = '{F_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
    mv[7] = '{F_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    mv[8] = '{F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};

    rst = 1'b1; start = 1'b0; func = F_SLL; opa = '0; opb = '0;
    start8 = 1'b0; func8 = F_SLL; opa8 = '0; opb8 = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    checkOutput("reset busy/done", {busy, done}, 2'b00);
    readHiLo("reset", 32'h0, 32'h0);
    checkOutput("reset zero on MFLO", zero, 1'b1);

    func = F_MTHI; opa = 32'h12345678;
    @(posedge clk); #1;
    func = F_MTLO; opa = 32'h9ABCDEF0;
    @(posedge clk); #1;
    readHiLo("mthi/mtlo", 32'h12345678, 32'h9ABCDEF0);

    for (int i = 0; i < 20; i++) begin
      applyStimulus(cv[i].func, cv[i].a, cv[i].b);
      checkOutput($sformatf("comb[%0d] res", i), res, cv[i].res);
      checkOutput($sformatf("comb[%0d] zero", i), zero, (cv[i].res == 32'h0));
      checkOutput($sformatf("comb[%0d] flags", i), {cout, uov, sov},
                  {cv[i].cout, cv[i].uov, cv[i].sov});
    end

    @(posedge clk); #1;
    for (int i = 0; i < 9; i++)
      runMulDiv($sformatf("muldiv[%0d]", i), mv[i].func, mv[i].a, mv[i].b, mv[i].hi, mv[i].lo);

    opa = 32'd3; opb = 32'd5; func = F_MULTU; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; func = F_MTHI; opa = 32'hDEADBEEF;
    n = 0;
    while (!done && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("mthi-while-busy latency", n, 33);
    readHiLo("mthi-while-busy", 32'h0, 32'd15);
    func = F_MTHI; opa = 32'hCAFEF00D;
    @(posedge clk); #1;
    readHiLo("mthi-in-done", 32'hCAFEF00D, 32'd15);

    opa = 32'hFFFFFFFD; opb = 32'd5; func = F_MULT; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dn = 0; first = 0;
    for (int k = 1; k <= 45; k++) begin
      @(posedge clk); #1;
      if (done) begin
        dn++;
        if (first == 0) first = k;
      end
      if (k == 10) begin
        start = 1'b1; func = F_MULTU; opa = 32'd7; opb = 32'd9;
      end
      if (k == 11) start = 1'b0;
    end
    checkOutput("start-while-busy done count", dn, 1);
    checkOutput("start-while-busy done cycle", first, 33);
    readHiLo("start-while-busy", 32'hFFFFFFFF, 32'hFFFFFFF1);

    opa = 32'hFFFFFFF9; opb = 32'd2; func = F_DIV; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (k == 5) begin
        func = F_MFHI;
        #1;
        checkOutput("MFHI while busy", res, 32'hFFFFFFFF);
        func = F_DIV;
      end
      if (k == 20) rst = 1'b1;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("mid-op reset busy/done", {busy, done}, 2'b00);
    readHiLo("mid-op reset", 32'h0, 32'h0);
    dn = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) dn++;
    end
    checkOutput("mid-op reset no done", dn, 0);
    runMulDiv("after reset", F_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);

    opa8 = 8'h81; opb8 = 8'h02; func8 = F_MULT; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    n = 0;
    while (!done8 && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("w8 MULT latency", n, 9);
    func8 = F_MFHI; #1;
    checkOutput("w8 MULT HI", res8, 8'hFF);
    func8 = F_MFLO; #1;
    checkOutput("w8 MULT LO", res8, 8'h02);
    func8 = F_SRA; opa8 = 8'h03; opb8 = 8'h80; #1;
    checkOutput("w8 SRA", res8, 8'hF0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
